// File: rtl/weight_updater_pkg.sv
// Shared definitions for the weight register bank: Q6.10 width, clamp limits, FSM states.
package weight_updater_pkg;
    localparam int QW = 16;
    localparam logic [QW-1:0] SAT_POS = 16'h7FFF;
    localparam logic [QW-1:0] SAT_NEG = 16'h8000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/weight_sat_add.sv
// Signed Q6.10 add for the weight update path; clamps on overflow when
// WEIGHT_UPDATER_SAT_EN is defined, otherwise wraps and never reports saturation.
module weight_sat_add
    import weight_updater_pkg::*;
(
    input  logic [QW-1:0] a,
    input  logic [QW-1:0] b,
    output logic [QW-1:0] sum,
    output logic          sat
);
`ifdef WEIGHT_UPDATER_SAT_EN
    logic [QW:0] s17;

    always_comb begin
        s17 = {a[QW-1], a} + {b[QW-1], b};
        sum = s17[QW-1:0];
        sat = 1'b0;
        // Top two bits disagree only when the true sum left the 16-bit range.
        if (s17[QW] != s17[QW-1]) begin
            sat = 1'b1;
            sum = s17[QW] ? SAT_NEG : SAT_POS;
        end
    end
`else
    always_comb begin
        sum = a + b;
        sat = 1'b0;
    end
`endif
endmodule

// File: rtl/weight_updater.sv
// Weight bank applying a stream of scaled deltas in frame order, with epoch counting.
// Saturating arithmetic is enabled by defining WEIGHT_UPDATER_SAT_EN.
module weight_updater
    import weight_updater_pkg::*;
#(
    parameter int NUM_W     = 4,
    parameter int AW        = 2,
    parameter int NUM_EPOCH = 1000,
    parameter int EW        = 10
) (
    input  logic          clk,
    input  logic          res,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [QW-1:0] load_data,
    input  logic          start,
    input  logic          dcdw_valid,
    input  logic [QW-1:0] dcdw,
    input  logic [AW-1:0] rd_addr,
    output logic [QW-1:0] rd_data,
    output logic          busy,
    output logic          frame_done,
    output logic          done,
    output logic [EW-1:0] epoch_cnt,
    output logic          sat_flag
);
    localparam int             IW         = (NUM_W > 1) ? $clog2(NUM_W) : 1;
    localparam logic [IW-1:0]  LAST_IDX   = IW'(NUM_W - 1);
    localparam logic [AW:0]    NUM_W_C    = (AW + 1)'(NUM_W);
    localparam logic [EW-1:0]  EPOCH_LAST = EW'(NUM_EPOCH - 1);

    logic [NUM_W-1:0][QW-1:0] w;
    state_t                   state;
    logic [IW-1:0]            idx;
    logic [QW-1:0]            upd_sum;
    logic                     upd_sat;
    logic                     rd_ok, load_ok;

    assign rd_ok   = ({1'b0, rd_addr}   < NUM_W_C);
    assign load_ok = ({1'b0, load_addr} < NUM_W_C);

    // Only one weight changes per cycle, so a single adder serves the whole bank.
    weight_sat_add u_add (
        .a   (w[idx]),
        .b   (dcdw),
        .sum (upd_sum),
        .sat (upd_sat)
    );

    always_ff @(posedge clk) begin
        if (!res) begin
            w          <= '0;
            state      <= IDLE;
            idx        <= '0;
            epoch_cnt  <= '0;
            rd_data    <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            done       <= 1'b0;
            sat_flag   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            rd_data    <= rd_ok ? w[rd_addr[IW-1:0]] : '0;
            case (state)
                IDLE, DONE: begin
                    if (load_en && load_ok)
                        w[load_addr[IW-1:0]] <= load_data;
                    if (start) begin
                        state     <= RUN;
                        idx       <= '0;
                        epoch_cnt <= '0;
                        sat_flag  <= 1'b0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                    end
                end
                RUN: begin
                    if (dcdw_valid) begin
                        w[idx] <= upd_sum;
                        if (upd_sat)
                            sat_flag <= 1'b1;
                        if (idx == LAST_IDX) begin
                            idx        <= '0;
                            epoch_cnt  <= epoch_cnt + 1'b1;
                            frame_done <= 1'b1;
                            if (epoch_cnt == EPOCH_LAST) begin
                                state <= DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_weight_updater.sv
// Self-checking bench for weight_updater: scenario tasks with a read-data scoreboard
// and a bench-side weight model; expectations follow WEIGHT_UPDATER_SAT_EN.
module tb_weight_updater;
    localparam int NUM_W     = 4;
    localparam int AW        = 3;
    localparam int NUM_EPOCH = 2;
    localparam int EW        = 10;

    logic          clk = 1'b0;
    logic          res, load_en, start, dcdw_valid;
    logic [AW-1:0] load_addr, rd_addr;
    logic [15:0]   load_data, dcdw;
    logic [15:0]   rd_data;
    logic          busy, frame_done, done, sat_flag;
    logic [EW-1:0] epoch_cnt;

    logic [15:0]   mdl [NUM_W];
    logic [15:0]   init_w [NUM_W];
    int            m_idx;
    logic          m_sat;
    logic [15:0]   exp_q [$];
    int            checks = 0;
    int            errors = 0;

    always #5 clk = ~clk;

    weight_updater #(.NUM_W(NUM_W), .AW(AW), .NUM_EPOCH(NUM_EPOCH), .EW(EW)) dut (
        .clk        (clk),
        .res        (res),
        .load_en    (load_en),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .start      (start),
        .dcdw_valid (dcdw_valid),
        .dcdw       (dcdw),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .busy       (busy),
        .frame_done (frame_done),
        .done       (done),
        .epoch_cnt  (epoch_cnt),
        .sat_flag   (sat_flag)
    );

    // Reference add: returns {clamped, result}.
    function automatic logic [16:0] madd(input logic [15:0] a, input logic [15:0] b);
        logic signed [16:0] s;
        s = $signed({a[15], a}) + $signed({b[15], b});
`ifdef WEIGHT_UPDATER_SAT_EN
        if (s > 17'sd32767)  return {1'b1, 16'h7FFF};
        if (s < -17'sd32768) return {1'b1, 16'h8000};
`endif
        return {1'b0, s[15:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        res = 1'b0; load_en = 1'b0; start = 1'b0; dcdw_valid = 1'b0;
        load_addr = '0; load_data = '0; dcdw = '0; rd_addr = '0;
        tick(); tick();
        res = 1'b1;
        for (int i = 0; i < NUM_W; i++) mdl[i] = '0;
        m_idx = 0; m_sat = 1'b0;
    endtask

    task automatic load_w(input int addr, input logic [15:0] data);
        load_en = 1'b1; load_addr = AW'(addr); load_data = data;
        tick();
        load_en = 1'b0;
        if (addr < NUM_W) mdl[addr] = data;
    endtask

    task automatic load_init();
        for (int i = 0; i < NUM_W; i++) load_w(i, init_w[i]);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        m_idx = 0; m_sat = 1'b0;
    endtask

    // One valid delta; returns frame_done as seen after the edge.
    task automatic upd(input logic [15:0] d, output logic fd);
        logic [16:0] r;
        dcdw_valid = 1'b1; dcdw = d;
        tick();
        dcdw_valid = 1'b0;
        fd = frame_done;
        r = madd(mdl[m_idx], d);
        mdl[m_idx] = r[15:0];
        m_sat = m_sat | r[16];
        m_idx = (m_idx + 1) % NUM_W;
    endtask

    // Drive a read address and queue the expected data for the next edge.
    task automatic queue_read(input int addr);
        rd_addr = AW'(addr);
        exp_q.push_back((addr < NUM_W) ? mdl[addr] : 16'h0000);
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", done); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %0b want 0", frame_done); end
        checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL reset_sat got %0b want 0", sat_flag); end
        checks++; if (epoch_cnt !== '0) begin errors++; $display("FAIL reset_epoch got %0d want 0", epoch_cnt); end
        checks++; if (rd_data !== 16'h0) begin errors++; $display("FAIL reset_rd_data got %h want 0000", rd_data); end
    endtask

    task automatic test_load();
        logic [15:0] e;
        load_init();
        load_w(5, 16'h1234);
        for (int i = 0; i < NUM_W + 2; i++) begin
            queue_read(i);
            e = exp_q.pop_front();
            checks++;
            if (rd_data !== e) begin errors++; $display("FAIL load_read[%0d] got %h want %h", i, rd_data, e); end
        end
    endtask

    task automatic test_frame();
        logic fd;
        int   fcnt;
        logic [15:0] e;
        do_start();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL frame_busy got %0b want 1", busy); end
        // Read and update weight 0 on the same edge: pre-update value expected.
        rd_addr = '0;
        exp_q.push_back(mdl[0]);
        fcnt = 0;
        upd(16'hFF9A, fd); fcnt += int'(fd);
        e = exp_q.pop_front();
        checks++; if (rd_data !== e) begin errors++; $display("FAIL frame_rd_pre got %h want %h", rd_data, e); end
        for (int i = 1; i < NUM_W; i++) begin upd(16'hFF9A, fd); fcnt += int'(fd); end
        checks++; if (fd !== 1'b1) begin errors++; $display("FAIL frame_done_last got %0b want 1", fd); end
        checks++; if (fcnt != 1) begin errors++; $display("FAIL frame_done_count got %0d want 1", fcnt); end
        checks++; if (epoch_cnt !== 10'd1) begin errors++; $display("FAIL frame_epoch got %0d want 1", epoch_cnt); end
        for (int i = 0; i < NUM_W; i++) begin
            queue_read(i);
            e = exp_q.pop_front();
            checks++;
            if (rd_data !== e) begin errors++; $display("FAIL frame_w[%0d] got %h want %h", i, rd_data, e); end
        end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL frame_done_pulse got %0b want 0", frame_done); end
    endtask

    task automatic test_gapped();
        logic fd;
        int   fcnt;
        logic [15:0] e;
        do_reset();
        load_init();
        do_start();
        fcnt = 0;
        for (int i = 0; i < NUM_W; i++) begin
            upd(16'hFF9A, fd); fcnt += int'(fd);
            // Idle gaps, with a load attempt that RUN must ignore.
            load_en = 1'b1; load_addr = '0; load_data = 16'h5555;
            for (int g = 0; g <= i; g++) begin tick(); fcnt += int'(frame_done); end
            load_en = 1'b0;
        end
        checks++; if (fcnt != 1) begin errors++; $display("FAIL gap_frame_done_count got %0d want 1", fcnt); end
        checks++; if (epoch_cnt !== 10'd1) begin errors++; $display("FAIL gap_epoch got %0d want 1", epoch_cnt); end
        for (int i = 0; i < NUM_W; i++) begin
            queue_read(i);
            e = exp_q.pop_front();
            checks++;
            if (rd_data !== e) begin errors++; $display("FAIL gap_w[%0d] got %h want %h", i, rd_data, e); end
        end
    endtask

    task automatic test_back_to_back();
        logic fd;
        logic [15:0] e;
        do_reset();
        load_init();
        do_start();
        for (int n = 0; n < NUM_W * NUM_EPOCH; n++) begin
            if (n == NUM_W * NUM_EPOCH - 1) begin
                checks++;
                if (busy !== 1'b1 || done !== 1'b0) begin
                    errors++; $display("FAIL b2b_before_last busy %0b done %0b want 1 0", busy, done);
                end
            end
            upd(16'h0001, fd);
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_done got %0b want 1", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy got %0b want 0", busy); end
        checks++; if (epoch_cnt !== 10'(NUM_EPOCH)) begin errors++; $display("FAIL b2b_epoch got %0d want %0d", epoch_cnt, NUM_EPOCH); end
        // Ninth valid: state is DONE, nothing may change.
        dcdw_valid = 1'b1; dcdw = 16'h0001;
        tick();
        dcdw_valid = 1'b0;
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL b2b_extra_fd got %0b want 0", frame_done); end
        for (int i = 0; i < NUM_W; i++) begin
            queue_read(i);
            e = exp_q.pop_front();
            checks++;
            if (rd_data !== e) begin errors++; $display("FAIL b2b_w[%0d] got %h want %h", i, rd_data, e); end
        end
        // DONE accepts loads and a fresh start.
        load_w(2, 16'h0ABC);
        queue_read(2);
        e = exp_q.pop_front();
        checks++; if (rd_data !== e) begin errors++; $display("FAIL done_load got %h want %h", rd_data, e); end
        do_start();
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || epoch_cnt !== '0) begin
            errors++; $display("FAIL restart busy %0b done %0b epoch %0d want 1 0 0", busy, done, epoch_cnt);
        end
    endtask

    task automatic test_saturation();
        logic fd;
        logic [15:0] e;
        do_reset();
        load_w(0, 16'h7F00);
        do_start();
        upd(16'h0200, fd);
        checks++; if (sat_flag !== m_sat) begin errors++; $display("FAIL sat_flag got %0b want %0b", sat_flag, m_sat); end
        queue_read(0);
        e = exp_q.pop_front();
        checks++; if (rd_data !== e) begin errors++; $display("FAIL sat_w0 got %h want %h", rd_data, e); end
        for (int n = 1; n < NUM_W * NUM_EPOCH; n++) upd(16'h0000, fd);
        checks++; if (sat_flag !== m_sat) begin errors++; $display("FAIL sat_sticky got %0b want %0b", sat_flag, m_sat); end
        do_start();
        checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL sat_clear got %0b want 0", sat_flag); end
    endtask

    task automatic test_mid_run_reset();
        logic fd;
        logic [15:0] e;
        do_reset();
        load_init();
        do_start();
        upd(16'h0010, fd);
        upd(16'h0010, fd);
        load_en = 1'b1; load_addr = 3'd3; load_data = 16'h5555;
        tick();
        load_en = 1'b0;
        queue_read(3);
        e = exp_q.pop_front();
        checks++; if (rd_data !== e) begin errors++; $display("FAIL run_load_ignored got %h want %h", rd_data, e); end
        res = 1'b0;
        tick();
        res = 1'b1;
        for (int i = 0; i < NUM_W; i++) mdl[i] = '0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || epoch_cnt !== '0) begin
            errors++; $display("FAIL midreset busy %0b done %0b epoch %0d want 0 0 0", busy, done, epoch_cnt);
        end
        // Valid in IDLE must not touch the bank.
        dcdw_valid = 1'b1; dcdw = 16'h0100;
        tick();
        dcdw_valid = 1'b0;
        for (int i = 0; i < NUM_W; i++) begin
            queue_read(i);
            e = exp_q.pop_front();
            checks++;
            if (rd_data !== e) begin errors++; $display("FAIL midreset_w[%0d] got %h want %h", i, rd_data, e); end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_valid_busy got %0b want 0", busy); end
    endtask

    initial begin
        init_w[0] = 16'h0400;
        init_w[1] = 16'hFC00;
        init_w[2] = 16'h0000;
        init_w[3] = 16'h0100;
        test_reset();
        test_load();
        test_frame();
        test_gapped();
        test_back_to_back();
        test_saturation();
        test_mid_run_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
